// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//   Runs the board RGB LED through a red -> green -> blue fade show. Each
//   colour ramps its brightness level up from 0 to MAX, holds at MAX for a
//   few ticks, then ramps back down to 0. One free-running PWM counter is
//   shared by all three LEDs; only the LED of the current colour can light.
//   Level and hold progress advance on prescaled ticks so the fade speed is
//   independent of the PWM frequency.
//
// Parameters
//   PWM_BITS    width of the PWM counter and brightness level
//   PRESCALE    clk cycles per tick (>= 1)
//   HOLD_TICKS  ticks spent at MAX before fading down (>= 1)
//
// Ports
//   clk     system clock, all state on posedge
//   rst     asynchronous active-low reset (0 = reset)
//   start   request a show, sampled only while idle
//   loop    restart at red after blue instead of going idle
//   stop    abort the show, has priority over start
//   busy    high while a show is running
//   done    one-cycle pulse when the blue fade-down completes
//   phase   0 idle, 1 fade up, 2 hold, 3 fade down
//   colour  0 red, 1 green, 2 blue (0 while idle)
//   led_r   registered PWM outputs, active-high
//   led_g
//   led_b

module rgb_fade_sequencer #(
    parameter int PWM_BITS   = 4,
    parameter int PRESCALE   = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       loop,
    input  logic       stop,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase,
    output logic [1:0] colour,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    // Counter widths are kept at least one bit so PRESCALE=1 / HOLD_TICKS=1 still elaborate.
    localparam int PS_W   = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);
    localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]     PS_ONE    = PS_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FADE_UP   = 2'd1,
        HOLD      = 2'd2,
        FADE_DOWN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [1:0]          colour_q, colour_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                done_d;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PS_W-1:0]     prescaler;
    logic                tick;

    assign busy   = (state_q != IDLE);
    assign phase  = state_q;
    assign colour = colour_q;
    assign tick   = busy && (prescaler == PS_LAST);

    // The PWM counter never stops, so the duty pattern is continuous across phases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + LEVEL_ONE;
        end
    end

    // The prescaler is deliberately not cleared between colours or phases so
    // ticks stay evenly spaced for the whole show; it only restarts from idle
    // or on an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
        end else if (!busy || stop) begin
            prescaler <= '0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            colour_q <= 2'd0;
            hold_q   <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            colour_q <= colour_d;
            hold_q   <= hold_d;
            done     <= done_d;
        end
    end

    // Sequencing: everything except leaving idle happens only on a tick.
    // An abort overrides whatever the tick would have done, including the
    // final done pulse.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        colour_d = colour_q;
        hold_d   = hold_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = FADE_UP;
                    level_d  = '0;
                    colour_d = 2'd0;
                end
            end
            FADE_UP: begin
                if (tick) begin
                    if (level_q != LEVEL_MAX) begin
                        level_d = level_q + LEVEL_ONE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = FADE_DOWN;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end
            end
            FADE_DOWN: begin
                if (tick) begin
                    if (level_q != '0) begin
                        level_d = level_q - LEVEL_ONE;
                    end else if (colour_q != 2'd2) begin
                        colour_d = colour_q + 2'd1;
                        state_d  = FADE_UP;
                    end else begin
                        done_d   = 1'b1;
                        colour_d = 2'd0;
                        state_d  = loop ? FADE_UP : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop && (state_q != IDLE)) begin
            state_d  = IDLE;
            level_d  = '0;
            colour_d = 2'd0;
            hold_d   = '0;
            done_d   = 1'b0;
        end
    end

    // LEDs are registered from the current level and PWM count, so they lag
    // one cycle and go dark on the cycle after idle is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= busy && (colour_q == 2'd0) && (pwm_cnt < level_q);
            led_g <= busy && (colour_q == 2'd1) && (pwm_cnt < level_q);
            led_b <= busy && (colour_q == 2'd2) && (pwm_cnt < level_q);
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer
//   Directed bench for rgb_fade_sequencer with PWM_BITS=4, PRESCALE=4,
//   HOLD_TICKS=2 (136 cycles per colour, 408 per show). Expected done pulses
//   are queued when a show is started; a monitor pops and compares them when
//   the design raises done.

module tb_rgb_fade_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       loop;
    logic       stop;
    logic       busy;
    logic       done;
    logic [1:0] phase;
    logic [1:0] colour;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    typedef struct {
        int         done_edge;
        logic       busy_after;
        logic [1:0] phase_after;
    } exp_t;

    exp_t sb_q[$];

    int edge_cnt   = 0;
    int tests_run  = 0;
    int tests_fail = 0;

    int r_high = 0;
    int g_high = 0;
    int b_high = 0;
    int multi_led_cycles = 0;
    int wrong_led_cycles = 0;
    logic       prev_busy   = 1'b0;
    logic [1:0] prev_colour = 2'd0;

    rgb_fade_sequencer #(
        .PWM_BITS   (4),
        .PRESCALE   (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .loop   (loop),
        .stop   (stop),
        .busy   (busy),
        .done   (done),
        .phase  (phase),
        .colour (colour),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    // Drives start/stop for exactly one edge; returns the edge that samples them.
    task automatic applyStimulus(input logic s_start, input logic s_stop, output int sampled_edge);
        start = s_start;
        stop  = s_stop;
        sampled_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic goToEdge(input int k);
        while (edge_cnt < k) @(negedge clk);
    endtask

    // Monitor: done scoreboard plus LED sanity against last cycle's state.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("done_edge", edge_cnt, e.done_edge);
                checkOutput("state_after_done", int'({busy, phase, colour}),
                            int'({e.busy_after, e.phase_after, 2'b00}));
            end
        end
        if (int'(led_r) + int'(led_g) + int'(led_b) > 1) multi_led_cycles++;
        if (led_r && !(prev_busy && prev_colour == 2'd0)) wrong_led_cycles++;
        if (led_g && !(prev_busy && prev_colour == 2'd1)) wrong_led_cycles++;
        if (led_b && !(prev_busy && prev_colour == 2'd2)) wrong_led_cycles++;
        if (led_r) r_high++;
        if (led_g) g_high++;
        if (led_b) b_high++;
        prev_busy   = busy;
        prev_colour = colour;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int e;
        int cnt;
        int r0, g0, b0;

        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", int'({busy, done, phase, colour, led_r, led_g, led_b}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_after_release", int'(busy), 0);

        // Asynchronous reset in the middle of a hold phase
        applyStimulus(1'b1, 1'b0, n);
        goToEdge(n + 66);
        checkOutput("phase_hold_mid_show", int'(phase), 2);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs", int'({busy, done, phase, colour, led_r, led_g, led_b}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle_until_start", int'({busy, phase}), 0);

        // Single show with duty and colour-order checks
        r0 = r_high; g0 = g_high; b0 = b_high;
        applyStimulus(1'b1, 1'b0, n);
        sb_q.push_back('{done_edge: n + 408, busy_after: 1'b0, phase_after: 2'd0});
        goToEdge(n + 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(led_r);
            @(negedge clk);
        end
        checkOutput("led_dark_at_level0", cnt, 0);
        goToEdge(n + 61);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cnt += int'(led_r);
            @(negedge clk);
        end
        checkOutput("duty_at_max", cnt, 15);
        goToEdge(n + 100);
        checkOutput("colour_red", int'(colour), 0);
        goToEdge(n + 200);
        checkOutput("colour_green", int'(colour), 1);
        goToEdge(n + 300);
        checkOutput("colour_blue", int'(colour), 2);
        goToEdge(n + 420);
        checkOutput("show_done_seen", sb_q.size(), 0);
        checkOutput("idle_after_show", int'(busy), 0);
        checkOutput("red_lit", int'(r_high > r0), 1);
        checkOutput("green_lit", int'(g_high > g0), 1);
        checkOutput("blue_lit", int'(b_high > b0), 1);

        // Looping show, loop dropped during the second pass
        loop = 1'b1;
        applyStimulus(1'b1, 1'b0, n);
        sb_q.push_back('{done_edge: n + 408, busy_after: 1'b1, phase_after: 2'd1});
        sb_q.push_back('{done_edge: n + 816, busy_after: 1'b0, phase_after: 2'd0});
        goToEdge(n + 420);
        loop = 1'b0;
        checkOutput("busy_in_second_pass", int'(busy), 1);
        goToEdge(n + 830);
        checkOutput("loop_dones_seen", sb_q.size(), 0);
        checkOutput("idle_after_loop", int'(busy), 0);

        // Stop during blue fade-down at level 1
        applyStimulus(1'b1, 1'b0, n);
        goToEdge(n + 401);
        applyStimulus(1'b0, 1'b1, e);
        checkOutput("stop_edge", e, n + 402);
        checkOutput("idle_after_stop", int'({busy, phase, colour}), 0);
        @(negedge clk);
        checkOutput("leds_dark_after_stop", int'({led_r, led_g, led_b}), 0);
        goToEdge(n + 420);
        checkOutput("no_done_after_stop", int'(busy), 0);

        // stop and start together while idle
        applyStimulus(1'b1, 1'b1, e);
        checkOutput("stop_start_idle", int'(busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("stop_start_idle_later", int'(busy), 0);

        // Extra start pulses while busy must not disturb the timing
        applyStimulus(1'b1, 1'b0, n);
        sb_q.push_back('{done_edge: n + 408, busy_after: 1'b0, phase_after: 2'd0});
        goToEdge(n + 49);
        applyStimulus(1'b1, 1'b0, e);
        goToEdge(n + 199);
        applyStimulus(1'b1, 1'b0, e);
        goToEdge(n + 300);
        checkOutput("colour_blue_restart_ignored", int'(colour), 2);
        goToEdge(n + 420);
        checkOutput("restart_done_seen", sb_q.size(), 0);
        checkOutput("idle_after_restart_show", int'(busy), 0);

        checkOutput("one_led_at_a_time", multi_led_cycles, 0);
        checkOutput("led_matches_colour", wrong_led_cycles, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
